// File: rtl/sys_ctrl_fsm_p.sv
// System-control FSM: sequences the CPU through RST/RUN/STP from debounced keys and
// mode switches, manages probe-ROM index / display address and UART tx-enable pulses.
module sys_ctrl_fsm_p #(
    parameter int          AW        = 12,
    parameter int          NCH       = 2,
    parameter int          DB_CYCLES = 1,
    parameter int          CW        = 8,
    parameter logic [3:0]  END_HDR   = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      key_n,
    input  logic [3:0]      sm,
    input  logic            insn_end,
    input  logic            intr_detected,
    input  logic            halted,
    input  logic [AW-1:0]   pc,
    input  logic            bp_en,
    input  logic [AW-1:0]   bp_addr,
    input  logic [CW-1:0]   step_n,
    input  logic [NCH-1:0]  fg_out,
    input  logic [31:0]     probe_info,
    output logic [1:0]      cpu_state,
    output logic [AW-1:0]   probe_idx,
    output logic [AW-1:0]   com_addr_r,
    output logic [NCH-1:0]  tx_enable,
    output logic [3:0]      key_evt,
    output logic [2:0]      stop_cause
);

    typedef enum logic [1:0] {
        ST_RST = 2'b00,
        ST_RUN = 2'b01,
        ST_STP = 2'b10
    } state_t;

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_MODE  = 3'd1;
    localparam logic [2:0] CAUSE_INTR  = 3'd2;
    localparam logic [2:0] CAUSE_STEP  = 3'd3;
    localparam logic [2:0] CAUSE_BP    = 3'd4;
    localparam logic [2:0] CAUSE_HKEY  = 3'd5;

    state_t          state_reg;
    logic [AW-1:0]   probe_idx_reg;
    logic [AW-1:0]   com_addr_reg;
    logic [2:0]      stop_cause_reg;
    logic [CW-1:0]   step_cnt_reg;

    // Per-key synchroniser and debouncer; a press is the 1->0 edge of the debounced level.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : key_g
            logic           sync1_reg;
            logic           sync2_reg;
            logic           db_reg;
            logic           db_prev_reg;
            logic [DBW-1:0] db_cnt_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_reg   <= 1'b1;
                    sync2_reg   <= 1'b1;
                    db_reg      <= 1'b1;
                    db_prev_reg <= 1'b1;
                    db_cnt_reg  <= '0;
                end else begin
                    sync1_reg   <= key_n[gi];
                    sync2_reg   <= sync1_reg;
                    db_prev_reg <= db_reg;
                    if (sync2_reg != db_reg) begin
                        if (db_cnt_reg == DB_LAST) begin
                            db_reg     <= sync2_reg;
                            db_cnt_reg <= '0;
                        end else begin
                            db_cnt_reg <= db_cnt_reg + DBW'(1);
                        end
                    end else begin
                        db_cnt_reg <= '0;
                    end
                end
            end

            assign key_evt[gi] = db_prev_reg & ~db_reg;
        end
    endgenerate

    // tx request on a 1->0 flag edge; the history is pinned high while in RST.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : tx_g
            logic prev_fg_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prev_fg_reg <= 1'b1;
                end else begin
                    prev_fg_reg <= (state_reg == ST_RST) ? 1'b1 : fg_out[gi];
                end
            end

            assign tx_enable[gi] = ~fg_out[gi] & prev_fg_reg & (state_reg != ST_RST);
        end
    endgenerate

    logic          src_bp;
    logic          src_intr;
    logic          src_step;
    logic          src_mode;
    logic          src_hkey;
    logic          stop_cond;
    logic [2:0]    cause_next;
    logic [CW-1:0] step_load;
    logic          hdr_end;
    logic          unused_bits;

    assign src_bp    = bp_en & insn_end & (pc == bp_addr);
    assign src_intr  = sm[1] & intr_detected;
    assign src_step  = sm[3] & insn_end & (step_cnt_reg == CW'(1));
    assign src_mode  = sm[2];
    assign src_hkey  = halted & key_evt[1];
    assign stop_cond = src_bp | src_intr | src_step | src_mode | src_hkey;
    assign step_load = (step_n == '0) ? CW'(1) : step_n;
    assign hdr_end   = (probe_info[31:28] == END_HDR);
    assign unused_bits = ^{probe_info, sm[0]};

    always_comb begin
        cause_next = CAUSE_NONE;
        if (src_bp)        cause_next = CAUSE_BP;
        else if (src_intr) cause_next = CAUSE_INTR;
        else if (src_step) cause_next = CAUSE_STEP;
        else if (src_mode) cause_next = CAUSE_MODE;
        else if (src_hkey) cause_next = CAUSE_HKEY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_RST;
            probe_idx_reg  <= '0;
            com_addr_reg   <= '0;
            stop_cause_reg <= CAUSE_NONE;
            step_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_RST: begin
                    probe_idx_reg <= '0;
                    com_addr_reg  <= '0;
                    if (key_evt[0]) begin
                        state_reg      <= ST_RUN;
                        step_cnt_reg   <= step_load;
                        stop_cause_reg <= CAUSE_NONE;
                    end else if (key_evt[1]) begin
                        state_reg <= ST_STP;
                    end
                end
                ST_RUN: begin
                    if (key_evt[0]) begin
                        state_reg     <= ST_RST;
                        probe_idx_reg <= '0;
                        com_addr_reg  <= '0;
                    end else begin
                        if (insn_end && step_cnt_reg != '0)
                            step_cnt_reg <= step_cnt_reg - CW'(1);
                        if (stop_cond) begin
                            state_reg      <= ST_STP;
                            com_addr_reg   <= pc;
                            stop_cause_reg <= cause_next;
                        end
                    end
                end
                ST_STP: begin
                    if (key_evt[0]) begin
                        state_reg     <= ST_RST;
                        probe_idx_reg <= '0;
                        com_addr_reg  <= '0;
                    end else if (key_evt[1]) begin
                        state_reg      <= ST_RUN;
                        step_cnt_reg   <= step_load;
                        stop_cause_reg <= CAUSE_NONE;
                    end else if (halted) begin
                        // Halted CPU: walk the probe ROM and show its address field.
                        if (key_evt[2] || hdr_end)
                            probe_idx_reg <= '0;
                        else if (key_evt[3])
                            probe_idx_reg <= probe_idx_reg + AW'(1);
                        com_addr_reg <= probe_info[16 +: AW];
                    end else begin
                        if (key_evt[2])
                            com_addr_reg <= '0;
                        else if (key_evt[3])
                            com_addr_reg <= com_addr_reg + AW'(1);
                    end
                end
                default: state_reg <= ST_RST;
            endcase
        end
    end

    assign cpu_state  = state_reg;
    assign probe_idx  = probe_idx_reg;
    assign com_addr_r = com_addr_reg;
    assign stop_cause = stop_cause_reg;

endmodule

// File: tb/tb_sys_ctrl_fsm_p.sv
// Randomised scenario bench for sys_ctrl_fsm_p with a spec-level expectation model.
module tb_sys_ctrl_fsm_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_n;
    logic [3:0]  sm;
    logic        insn_end;
    logic        intr_detected;
    logic        halted;
    logic [11:0] pc;
    logic        bp_en;
    logic [11:0] bp_addr;
    logic [7:0]  step_n;
    logic [1:0]  fg_out;
    logic [31:0] probe_info;
    logic [1:0]  cpu_state;
    logic [11:0] probe_idx;
    logic [11:0] com_addr_r;
    logic [1:0]  tx_enable;
    logic [3:0]  key_evt;
    logic [2:0]  stop_cause;

    int checks   = 0;
    int failures = 0;
    int m_state  = 0;   // 0 RST, 1 RUN, 2 STP

    sys_ctrl_fsm_p #(.AW(12), .NCH(2), .DB_CYCLES(4), .CW(8), .END_HDR(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .sm(sm), .insn_end(insn_end),
        .intr_detected(intr_detected), .halted(halted), .pc(pc), .bp_en(bp_en),
        .bp_addr(bp_addr), .step_n(step_n), .fg_out(fg_out), .probe_info(probe_info),
        .cpu_state(cpu_state), .probe_idx(probe_idx), .com_addr_r(com_addr_r),
        .tx_enable(tx_enable), .key_evt(key_evt), .stop_cause(stop_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press a key for 10 clocks and release; the event must arrive 6 clocks after the first sample.
    task automatic press_key(input int k);
        int lat;
        logic [3:0] exp_evt;
        logic seen;
        lat = 0;
        exp_evt = 4'b0001 << k;
        key_n[k] = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (key_evt != 4'b0000) begin
                lat = t;
                break;
            end
        end
        checks++;
        if (lat != 6 || key_evt !== exp_evt) begin
            failures++;
            $display("FAIL press_latency key%0d: latency=%0d evt=%b, required latency=6 evt=%b",
                     k, lat, key_evt, exp_evt);
        end
        tick();
        checks++;
        if (key_evt !== 4'b0000) begin
            failures++;
            $display("FAIL press_width key%0d: evt=%b one cycle later, required 0000", k, key_evt);
        end
        repeat (3) tick();
        key_n[k] = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (key_evt != 4'b0000) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL release_evt key%0d: event seen on release, required none", k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cpu_state, probe_idx, com_addr_r, stop_cause, tx_enable, key_evt} !== '0) begin
            failures++;
            $display("FAIL reset_values: state=%b idx=%h com=%h cause=%0d tx=%b evt=%b, required all zero",
                     cpu_state, probe_idx, com_addr_r, stop_cause, tx_enable, key_evt);
        end
        rst_n = 1'b1;
        tick();
        m_state = 0;
    endtask

    task automatic test_debounce();
        logic bad;
        bad = 1'b0;
        key_n[0] = 1'b0;
        repeat (3) tick();
        key_n[0] = 1'b1;
        repeat (12) begin
            tick();
            if (key_evt != 4'b0000 || cpu_state != 2'b00) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL glitch_filter: event or state change from 3-clock glitch, required none");
        end
        press_key(0);
        m_state = 1;
        checks++;
        if (cpu_state !== 2'b01 || stop_cause !== 3'd0) begin
            failures++;
            $display("FAIL key0_to_run: state=%b cause=%0d, required 01 cause 0", cpu_state, stop_cause);
        end
    endtask

    task automatic test_reset_mid_run();
        logic bad;
        bad = 1'b0;
        key_n = 4'b1110;
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            if ({cpu_state, probe_idx, com_addr_r, stop_cause, tx_enable, key_evt} != '0) bad = 1'b1;
        end
        key_n = 4'b1111;
        tick();
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            if (cpu_state != 2'b00 || key_evt != 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid_run: state=%b evt=%b, required RST with no events", cpu_state, key_evt);
        end
        m_state = 0;
    endtask

    task automatic test_step();
        int sn;
        int expected;
        logic [11:0] p;
        sm = 4'b1000;
        bp_en = 1'b0;
        for (int trial = 0; trial < 5; trial++) begin
            sn = (trial == 0) ? 3 : (trial == 1) ? 0 : int'($urandom_range(0, 6));
            expected = (sn == 0) ? 1 : sn;
            step_n = 8'(sn);
            if (m_state == 0) press_key(0);
            else press_key(1);
            m_state = 1;
            checks++;
            if (cpu_state !== 2'b01 || stop_cause !== 3'd0) begin
                failures++;
                $display("FAIL step_enter: state=%b cause=%0d, required 01 cause 0", cpu_state, stop_cause);
            end
            for (int n = 1; n <= expected; n++) begin
                repeat ($urandom_range(0, 3)) tick();
                p = 12'($urandom_range(0, 4095));
                pc = p;
                insn_end = 1'b1;
                tick();
                insn_end = 1'b0;
                checks++;
                if (n < expected) begin
                    if (cpu_state !== 2'b01) begin
                        failures++;
                        $display("FAIL step_early n=%0d of %0d: state=%b, required 01", n, expected, cpu_state);
                    end
                end else begin
                    if (cpu_state !== 2'b10 || stop_cause !== 3'd3 || com_addr_r !== p) begin
                        failures++;
                        $display("FAIL step_stop step_n=%0d: state=%b cause=%0d com=%h, required 10 cause 3 com=%h",
                                 sn, cpu_state, stop_cause, com_addr_r, p);
                    end
                end
            end
            m_state = 2;
        end
        sm = 4'b0001;
    endtask

    task automatic test_breakpoint();
        logic [11:0] p;
        logic [11:0] bp;
        sm = 4'b0001;
        bp_en = 1'b1;
        for (int trial = 0; trial < 3; trial++) begin
            bp = (trial == 0) ? 12'h010 : 12'($urandom_range(0, 4095));
            bp_addr = bp;
            if (trial == 2) sm = 4'b0010;
            press_key(1);
            repeat ($urandom_range(1, 4)) begin
                do p = 12'($urandom_range(0, 4095)); while (p == bp);
                pc = p;
                insn_end = 1'b1;
                tick();
                insn_end = 1'b0;
                checks++;
                if (cpu_state !== 2'b01) begin
                    failures++;
                    $display("FAIL bp_miss pc=%h bp=%h: state=%b, required 01", p, bp, cpu_state);
                end
            end
            pc = bp;
            insn_end = 1'b1;
            intr_detected = (trial == 2);
            tick();
            insn_end = 1'b0;
            intr_detected = 1'b0;
            checks++;
            if (cpu_state !== 2'b10 || stop_cause !== 3'd4 || com_addr_r !== bp) begin
                failures++;
                $display("FAIL bp_hit trial=%0d: state=%b cause=%0d com=%h, required 10 cause 4 com=%h",
                         trial, cpu_state, stop_cause, com_addr_r, bp);
            end
        end
        bp_en = 1'b0;
        sm = 4'b0001;
        m_state = 2;
    endtask

    task automatic test_stop_sources();
        logic [11:0] p;
        // interrupt stop
        sm = 4'b0010;
        press_key(1);
        p = 12'($urandom_range(0, 4095));
        pc = p;
        intr_detected = 1'b1;
        tick();
        intr_detected = 1'b0;
        checks++;
        if (cpu_state !== 2'b10 || stop_cause !== 3'd2 || com_addr_r !== p) begin
            failures++;
            $display("FAIL intr_stop: state=%b cause=%0d com=%h, required 10 cause 2 com=%h",
                     cpu_state, stop_cause, com_addr_r, p);
        end
        // mode stop
        sm = 4'b0001;
        press_key(1);
        p = 12'($urandom_range(0, 4095));
        pc = p;
        sm = 4'b0100;
        tick();
        sm = 4'b0001;
        checks++;
        if (cpu_state !== 2'b10 || stop_cause !== 3'd1 || com_addr_r !== p) begin
            failures++;
            $display("FAIL mode_stop: state=%b cause=%0d com=%h, required 10 cause 1 com=%h",
                     cpu_state, stop_cause, com_addr_r, p);
        end
        // halted + KEY1 stop; once in STP the display follows the probe word
        press_key(1);
        probe_info = {4'h2, 12'($urandom_range(0, 4095)), 16'($urandom_range(0, 65535))};
        halted = 1'b1;
        tick();
        press_key(1);
        checks++;
        if (cpu_state !== 2'b10 || stop_cause !== 3'd5 || com_addr_r !== probe_info[27:16]) begin
            failures++;
            $display("FAIL halt_key_stop: state=%b cause=%0d com=%h, required 10 cause 5 com=%h",
                     cpu_state, stop_cause, com_addr_r, probe_info[27:16]);
        end
        m_state = 2;
    endtask

    task automatic test_probe();
        logic [11:0] m_idx;
        halted = 1'b1;
        probe_info = {4'h1, 12'h123, 16'h0};
        press_key(2);
        m_idx = 12'h000;
        checks++;
        if (probe_idx !== m_idx) begin
            failures++;
            $display("FAIL probe_key2: idx=%h, required %h", probe_idx, m_idx);
        end
        for (int i = 0; i < 5; i++) begin
            probe_info = {4'($urandom_range(0, 14)), 12'($urandom_range(0, 4095)), 16'($urandom_range(0, 65535))};
            press_key(3);
            m_idx = m_idx + 12'h001;
            checks++;
            if (probe_idx !== m_idx || com_addr_r !== probe_info[27:16]) begin
                failures++;
                $display("FAIL probe_step i=%0d: idx=%h com=%h, required idx=%h com=%h",
                         i, probe_idx, com_addr_r, m_idx, probe_info[27:16]);
            end
        end
        probe_info[31:28] = 4'hF;
        tick();
        checks++;
        if (probe_idx !== 12'h000) begin
            failures++;
            $display("FAIL probe_end_hdr: idx=%h, required 000", probe_idx);
        end
        probe_info = {4'h1, 12'hFFF, 16'h0};
        tick();
        halted = 1'b0;
        checks++;
        if (com_addr_r !== 12'hFFF) begin
            failures++;
            $display("FAIL com_load_fff: com=%h, required FFF", com_addr_r);
        end
        press_key(3);
        checks++;
        if (com_addr_r !== 12'h000) begin
            failures++;
            $display("FAIL com_wrap: com=%h, required 000", com_addr_r);
        end
        press_key(3);
        press_key(3);
        checks++;
        if (com_addr_r !== 12'h002) begin
            failures++;
            $display("FAIL com_inc: com=%h, required 002", com_addr_r);
        end
        press_key(2);
        checks++;
        if (com_addr_r !== 12'h000) begin
            failures++;
            $display("FAIL com_key2: com=%h, required 000", com_addr_r);
        end
    endtask

    task automatic test_tx();
        logic [1:0] prev;
        logic [1:0] nf;
        logic [1:0] exp_tx;
        fg_out = 2'b11;
        press_key(1);
        m_state = 1;
        tick();
        prev = 2'b11;
        for (int i = 0; i < 24; i++) begin
            nf = (i == 0 || i == 1) ? 2'b00 : 2'($urandom_range(0, 3));
            exp_tx = prev & ~nf;
            fg_out = nf;
            #1;
            checks++;
            if (tx_enable !== exp_tx) begin
                failures++;
                $display("FAIL tx_run i=%0d prev=%b fg=%b: tx=%b, required %b", i, prev, nf, tx_enable, exp_tx);
            end
            tick();
            prev = nf;
        end
        fg_out = 2'b11;
        press_key(0);
        m_state = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            nf = (i == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            fg_out = nf;
            #1;
            checks++;
            if (tx_enable !== 2'b00) begin
                failures++;
                $display("FAIL tx_rst i=%0d fg=%b: tx=%b, required 00", i, nf, tx_enable);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 4'b1111;
        sm = 4'b0001;
        insn_end = 1'b0;
        intr_detected = 1'b0;
        halted = 1'b0;
        pc = 12'h000;
        bp_en = 1'b0;
        bp_addr = 12'h000;
        step_n = 8'd1;
        fg_out = 2'b11;
        probe_info = 32'h1000_0000;
        test_reset();
        test_debounce();
        test_reset_mid_run();
        test_step();
        test_breakpoint();
        test_stop_sources();
        test_probe();
        test_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
